button_conditioner: RTL



---
 rtl/button_conditioner_if.sv | 34 +++
 rtl/button_conditioner.sv | 81 ++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw board buttons in,
// debounced levels, press pulses and motor-control settings out.
interface button_conditioner_if;
    logic       button1_raw;
    logic       button2_raw;
    logic       b1_level;
    logic       b2_level;
    logic       step_pulse;
    logic       dir_pulse;
    logic [1:0] duty_sel;
    logic       dir_level;

    modport master (
        output button1_raw,
        output button2_raw,
        input  b1_level,
        input  b2_level,
        input  step_pulse,
        input  dir_pulse,
        input  duty_sel,
        input  dir_level
    );

    modport slave (
        input  button1_raw,
        input  button2_raw,
        output b1_level,
        output b2_level,
        output step_pulse,
        output dir_pulse,
        output duty_sel,
        output dir_level
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: sync, debounce, press pulse,
// then duty-select stepping (button 1) and direction toggling (button 2).
module button_conditioner #(
    parameter int DEBOUNCE_CNT = 120000,
    parameter int CNT_W        = 17,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [1:0] raw_p;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] stable;
    logic [1:0] pulse;
    logic [1:0] duty_q;
    logic       dir_q;

    assign raw_p = {bus.button2_raw, bus.button1_raw} ^ {2{ACTIVE_LOW}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= raw_p;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             stb;
        logic             pls;

        // Pulse is raised on the same edge the stable level is accepted high.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                stb <= 1'b0;
                pls <= 1'b0;
            end else begin
                pls <= 1'b0;
                if (s2[i] == stb) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt <= '0;
                    stb <= s2[i];
                    pls <= s2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable[i] = stb;
        assign pulse[i]  = pls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 2'b00;
            dir_q  <= 1'b0;
        end else begin
            if (pulse[0]) duty_q <= duty_q + 2'd1;
            if (pulse[1]) dir_q  <= ~dir_q;
        end
    end

    assign bus.b1_level   = stable[0];
    assign bus.b2_level   = stable[1];
    assign bus.step_pulse = pulse[0];
    assign bus.dir_pulse  = pulse[1];
    assign bus.duty_sel   = duty_q;
    assign bus.dir_level  = dir_q;

endmodule
